// File: rtl/mem_lsu.sv
// Load/store unit: runs one data-memory access per ls_valid over a req/gnt + rvalid bus,
// stalling the core meanwhile and returning extended load data with a one-cycle done pulse.
module mem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_valid,
  input  logic        ls_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_mem,
  input  logic [31:0] data_store,
  output logic        stall,
  output logic        ls_done,
  output logic        ls_err,
  output logic [31:0] data_load,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_off, w_off_nxt;
  logic [2:0]       r_f3, w_f3_nxt;
  logic             r_store, w_store_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_bus_req, w_bus_req_nxt;
  logic             r_bus_we, w_bus_we_nxt;
  logic [31:0]      r_bus_addr, w_bus_addr_nxt;
  logic [3:0]       r_bus_wstrb, w_bus_wstrb_nxt;
  logic [31:0]      r_bus_wdata, w_bus_wdata_nxt;
  logic             r_ls_done, w_ls_done_nxt;
  logic             r_ls_err, w_ls_err_nxt;
  logic [31:0]      r_data_load, w_data_load_nxt;

  logic             w_legal;
  logic             w_aligned;
  logic             w_timeout;

  // Select the addressed lane and sign/zero-extend per funct3
  function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  always_comb begin
    w_legal = ls_store ? (funct3 < 3'd3)
                       : (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7);
    case (funct3[1:0])
      2'd0:    w_aligned = 1'b1;
      2'd1:    w_aligned = ~addr_mem[0];
      default: w_aligned = (addr_mem[1:0] == 2'd0);
    endcase
  end

  assign w_timeout = (r_cnt == LP_TO_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_off_nxt       = r_off;
    w_f3_nxt        = r_f3;
    w_store_nxt     = r_store;
    w_cnt_nxt       = r_cnt;
    w_bus_req_nxt   = r_bus_req;
    w_bus_we_nxt    = r_bus_we;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_wstrb_nxt = r_bus_wstrb;
    w_bus_wdata_nxt = r_bus_wdata;
    w_ls_done_nxt   = 1'b0;
    w_ls_err_nxt    = 1'b0;
    w_data_load_nxt = r_data_load;

    case (r_state)
      S_IDLE: begin
        if (ls_valid) begin
          w_off_nxt   = addr_mem[1:0];
          w_f3_nxt    = funct3;
          w_store_nxt = ls_store;
          w_cnt_nxt   = '0;
          if (w_legal && w_aligned) begin
            w_state_nxt     = S_REQ;
            w_bus_req_nxt   = 1'b1;
            w_bus_we_nxt    = ls_store;
            w_bus_addr_nxt  = {addr_mem[31:2], 2'b00};
            w_bus_wstrb_nxt = 4'd0;
            w_bus_wdata_nxt = 32'd0;
            if (ls_store) begin
              case (funct3[1:0])
                2'd0: begin
                  w_bus_wstrb_nxt = 4'b0001 << addr_mem[1:0];
                  w_bus_wdata_nxt = {4{data_store[7:0]}};
                end
                2'd1: begin
                  w_bus_wstrb_nxt = 4'b0011 << addr_mem[1:0];
                  w_bus_wdata_nxt = {2{data_store[15:0]}};
                end
                default: begin
                  w_bus_wstrb_nxt = 4'hF;
                  w_bus_wdata_nxt = data_store;
                end
              endcase
            end
          end else begin
            w_state_nxt   = S_DONE;
            w_ls_done_nxt = 1'b1;
            w_ls_err_nxt  = 1'b1;
          end
        end
      end
      // Grant takes priority over an expiring timeout in the same cycle
      S_REQ: begin
        if (bus_gnt) begin
          w_bus_req_nxt = 1'b0;
          w_cnt_nxt     = r_cnt + 1'b1;
          if (r_store) begin
            w_state_nxt   = S_DONE;
            w_ls_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RSP;
          end
        end else if (w_timeout) begin
          w_bus_req_nxt = 1'b0;
          w_state_nxt   = S_DONE;
          w_ls_done_nxt = 1'b1;
          w_ls_err_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RSP: begin
        if (bus_rvalid) begin
          w_data_load_nxt = f_extend(r_f3, r_off, bus_rdata);
          w_state_nxt     = S_DONE;
          w_ls_done_nxt   = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt   = S_DONE;
          w_ls_done_nxt = 1'b1;
          w_ls_err_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_off       <= '0;
      r_f3        <= '0;
      r_store     <= 1'b0;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wstrb <= '0;
      r_bus_wdata <= '0;
      r_ls_done   <= 1'b0;
      r_ls_err    <= 1'b0;
      r_data_load <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_off       <= w_off_nxt;
      r_f3        <= w_f3_nxt;
      r_store     <= w_store_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_wstrb <= w_bus_wstrb_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_ls_done   <= w_ls_done_nxt;
      r_ls_err    <= w_ls_err_nxt;
      r_data_load <= w_data_load_nxt;
    end
  end

  // Stall must rise in the same cycle execute presents the access
  assign stall = ~rst & (((r_state == S_IDLE) & ls_valid) | (r_state == S_REQ) |
                         (r_state == S_RSP));

  assign ls_done   = r_ls_done;
  assign ls_err    = r_ls_err;
  assign data_load = r_data_load;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wstrb = r_bus_wstrb;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus random accesses against a
// byte-level reference model of RV32I load/store semantics and bus timing.
module tb_mem_lsu;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid, ls_store;
  logic [2:0]  funct3;
  logic [31:0] addr_mem, data_store;
  logic        stall, ls_done, ls_err;
  logic [31:0] data_load;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_dl = 32'd0;

  mem_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .ls_store(ls_store), .funct3(funct3),
    .addr_mem(addr_mem), .data_store(data_store), .stall(stall), .ls_done(ls_done),
    .ls_err(ls_err), .data_load(data_load), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access; gd = idle cycles before gnt, rd = cycles after first RSP cycle before rvalid
  task automatic do_access(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d, input int gd,
                           input int rd, input logic [31:0] rdat);
    int          size, off, done_c, rv_c;
    bit          legal, ok, err;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_load;
    logic [7:0]  wb [4];
    logic [7:0]  rb [4];

    size  = 1 << (f3 % 4);
    off   = a % 4;
    legal = st ? (f3 < 3) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ok    = legal && (f3 % 4 != 3) && (a % size == 0);

    for (int i = 0; i < 4; i++) begin
      wb[i] = 8'(d >> (8 * (i % size)));
      rb[i] = 8'(rdat >> (8 * i));
    end
    e_strb  = 4'd0;
    e_wdata = {wb[3], wb[2], wb[1], wb[0]};
    if (st) for (int i = 0; i < size; i++) e_strb[off + i] = 1'b1;
    else e_wdata = 32'd0;
    e_load = 32'd0;
    for (int i = 0; i < size && ok; i++) e_load = e_load + (32'(rb[off + i]) << (8 * i));
    if (ok && f3 < 2 && e_load[8 * size - 1]) e_load = e_load - (32'd1 << (8 * size));

    ls_valid = 1'b1; ls_store = st; funct3 = f3; addr_mem = a; data_store = d;
    #1 chk({tag, ".stall_req"}, 32'(stall), 32'd1);
    @(posedge clk); #1;

    if (!ok) begin
      chk({tag, ".err_done"}, 32'(ls_done), 32'd1);
      chk({tag, ".err_flag"}, 32'(ls_err), 32'd1);
      chk({tag, ".err_noreq"}, 32'(bus_req), 32'd0);
      chk({tag, ".err_dl"}, data_load, exp_dl);
      ls_valid = 1'b0;
      @(posedge clk); #1;
      chk({tag, ".err_pulse"}, 32'(ls_done), 32'd0);
      return;
    end

    rv_c = gd + 2 + rd;
    if (gd >= int'(TO)) begin done_c = TO + 1; err = 1'b1; end
    else if (st) begin done_c = gd + 2; err = 1'b0; end
    else if (rv_c <= int'(TO)) begin done_c = rv_c + 1; err = 1'b0; end
    else begin done_c = TO + 1; err = 1'b1; end

    for (int c = 1; c < done_c; c++) begin
      chk({tag, ".stall"}, 32'(stall), 32'd1);
      chk({tag, ".busy_done"}, 32'(ls_done), 32'd0);
      if (c <= gd + 1) begin
        chk({tag, ".req"}, 32'(bus_req), 32'd1);
        chk({tag, ".addr"}, bus_addr, a & 32'hFFFF_FFFC);
        chk({tag, ".we"}, 32'(bus_we), 32'(st));
        chk({tag, ".wstrb"}, 32'(bus_wstrb), 32'(e_strb));
        if (st) chk({tag, ".wdata"}, bus_wdata, e_wdata);
        bus_gnt    = (c == gd + 1);
        bus_rvalid = 1'($urandom);
        bus_rdata  = $urandom;
      end else begin
        chk({tag, ".req_drop"}, 32'(bus_req), 32'd0);
        bus_gnt    = 1'b0;
        bus_rvalid = (c == rv_c);
        bus_rdata  = (c == rv_c) ? rdat : $urandom;
      end
      @(posedge clk); #1;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;

    if (!err && !st) exp_dl = e_load;
    chk({tag, ".done"}, 32'(ls_done), 32'd1);
    chk({tag, ".err"}, 32'(ls_err), 32'(err));
    chk({tag, ".done_noreq"}, 32'(bus_req), 32'd0);
    chk({tag, ".done_nostall"}, 32'(stall), 32'd0);
    chk({tag, ".data_load"}, data_load, exp_dl);
    ls_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".pulse_end"}, 32'(ls_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ls_valid = 1'b0; ls_store = 1'b0; funct3 = 3'd0;
    addr_mem = 32'd0; data_store = 32'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.done", 32'(ls_done), 32'd0);
    chk("rst.err", 32'(ls_err), 32'd0);
    chk("rst.req", 32'(bus_req), 32'd0);
    chk("rst.dl", data_load, 32'd0);
    chk("rst.wstrb", 32'(bus_wstrb), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_access("lw",  1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    do_access("lb",  1'b0, 3'd0, 32'h203, 32'h0, 0, 0, 32'h80FF_0000);
    do_access("lbu", 1'b0, 3'd4, 32'h203, 32'h0, 0, 0, 32'h80FF_0000);
    do_access("lh",  1'b0, 3'd1, 32'h202, 32'h0, 1, 2, 32'h9ABC_1234);
    do_access("lhu", 1'b0, 3'd5, 32'h202, 32'h0, 0, 1, 32'h9ABC_1234);
    do_access("sh",  1'b1, 3'd1, 32'h32, 32'h1234ABCD, 4, 0, 32'h0);
    do_access("sb",  1'b1, 3'd0, 32'h41, 32'h0000_00A5, 0, 0, 32'h0);
    do_access("sw",  1'b1, 3'd2, 32'h80, 32'hCAFE_F00D, 2, 0, 32'h0);
    do_access("lh_mis", 1'b0, 3'd1, 32'h41, 32'h0, 0, 0, 32'h0);
    do_access("lw_mis", 1'b0, 3'd2, 32'h42, 32'h0, 0, 0, 32'h0);
    do_access("ld_ill", 1'b0, 3'd6, 32'h40, 32'h0, 0, 0, 32'h0);
    do_access("st_ill", 1'b1, 3'd4, 32'h40, 32'h0, 0, 0, 32'h0);
    do_access("lw_to",  1'b0, 3'd2, 32'h300, 32'h0, 20, 0, 32'h0);
    do_access("rsp_to", 1'b0, 3'd2, 32'h304, 32'h0, 1, 9, 32'h0);
    do_access("sw_gnt_last", 1'b1, 3'd2, 32'h308, 32'h11223344, 7, 0, 32'h0);
    do_access("lw_rv_last",  1'b0, 3'd2, 32'h30C, 32'h0, 2, 4, 32'h5566_7788);

    // Reset asserted while waiting for read data
    ls_valid = 1'b1; ls_store = 1'b0; funct3 = 3'd2; addr_mem = 32'h400;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst.req", 32'(bus_req), 32'd0);
    chk("mid_rst.stall", 32'(stall), 32'd0);
    chk("mid_rst.done", 32'(ls_done), 32'd0);
    chk("mid_rst.dl", data_load, 32'd0);
    exp_dl   = 32'd0;
    ls_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_access("post_rst_lw", 1'b0, 3'd2, 32'h404, 32'h0, 0, 0, 32'h0BAD_F00D);

    for (int n = 0; n < 60; n++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      int          gd, rd;
      st = 1'($urandom);
      f3 = ($urandom_range(0, 9) < 8) ? (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7)))
                                       : 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'd2) ? 2'd0 : {a[1], 1'b0};
      gd = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 10) : $urandom_range(0, 4);
      rd = $urandom_range(0, 5);
      do_access("rand", st, f3, a, $urandom, gd, rd, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
